// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the EX/MEM boundary: branch condition codes and
// flag-write selects produced by the decoder.
package ex_mem_stage_pkg;

    localparam logic [2:0] COND_NEQ    = 3'd0;
    localparam logic [2:0] COND_EQ     = 3'd1;
    localparam logic [2:0] COND_GT     = 3'd2;
    localparam logic [2:0] COND_LT     = 3'd3;
    localparam logic [2:0] COND_GTE    = 3'd4;
    localparam logic [2:0] COND_LTE    = 3'd5;
    localparam logic [2:0] COND_OVFL   = 3'd6;
    localparam logic [2:0] COND_UNCOND = 3'd7;

    localparam logic [1:0] FWE_NONE = 2'b00;
    localparam logic [1:0] FWE_Z    = 2'b01;
    localparam logic [1:0] FWE_NVZ  = 2'b10;

endpackage

// File: rtl/ex_mem_stage_br_cond.sv
// Combinational branch-condition evaluator: (n, v, z, cond) -> take.
module br_cond
    import ex_mem_stage_pkg::*;
(
    input  logic       n,
    input  logic       v,
    input  logic       z,
    input  logic [2:0] cond,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond)
            COND_NEQ:    take = ~z;
            COND_EQ:     take = z;
            COND_GT:     take = ~z & ~n;
            COND_LT:     take = n;
            COND_GTE:    take = z | ~n;
            COND_LTE:    take = n | z;
            COND_OVFL:   take = v;
            COND_UNCOND: take = 1'b1;
            default:     take = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX-to-MEM pipeline boundary: owns the N/V/Z flag register, resolves
// conditional branches against it, and registers results into MEM.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          ex_valid,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_n,
    input  logic          ex_v,
    input  logic          ex_z,
    input  logic [1:0]    ex_flag_we,
    input  logic          ex_is_branch,
    input  logic [2:0]    ex_cond,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_regwrite,
    input  logic          ex_memread,
    input  logic          ex_memwrite,
    output logic          flag_n,
    output logic          flag_v,
    output logic          flag_z,
    output logic          br_taken,
    output logic          mem_valid,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_rd,
    output logic          mem_regwrite,
    output logic          mem_memread,
    output logic          mem_memwrite
);

    logic cap;
    logic cond_true;
    logic ctrl_ok;

    assign cap     = ex_valid & ~stall & ~flush;
    // Branches travel down the pipe as valid slots that never write anything.
    assign ctrl_ok = ex_valid & ~ex_is_branch;

    br_cond u_br_cond (
        .n    (flag_n),
        .v    (flag_v),
        .z    (flag_z),
        .cond (ex_cond),
        .take (cond_true)
    );

    assign br_taken = ~rst & cap & ex_is_branch & cond_true;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_v <= 1'b0;
            flag_z <= 1'b0;
        end else if (cap && !ex_is_branch) begin
            case (ex_flag_we)
                FWE_NVZ: begin
                    flag_n <= ex_n;
                    flag_v <= ex_v;
                    flag_z <= ex_z;
                end
                FWE_Z:   flag_z <= ex_z;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else if (flush) begin
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_regwrite   <= ex_regwrite & ctrl_ok;
            mem_memread    <= ex_memread & ctrl_ok;
            mem_memwrite   <= ex_memwrite & ctrl_ok;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall, flush, ex_valid;
    logic [15:0] ex_result, ex_store_data;
    logic        ex_n, ex_v, ex_z;
    logic [1:0]  ex_flag_we;
    logic        ex_is_branch;
    logic [2:0]  ex_cond;
    logic [3:0]  ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic        flag_n, flag_v, flag_z, br_taken, mem_valid;
    logic [15:0] mem_result, mem_store_data;
    logic [3:0]  mem_rd;
    logic        mem_regwrite, mem_memread, mem_memwrite;

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 1'b0;

    // model state
    logic        m_n = 0, m_v = 0, m_z = 0;
    logic        m_valid = 0, m_rw = 0, m_mr = 0, m_mw = 0;
    logic [15:0] m_res = 0, m_sd = 0;
    logic [3:0]  m_rd = 0;

    ex_mem_stage #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_n(ex_n), .ex_v(ex_v), .ex_z(ex_z), .ex_flag_we(ex_flag_we),
        .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .flag_n(flag_n), .flag_v(flag_v), .flag_z(flag_z), .br_taken(br_taken),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic n, input logic v, input logic z, input logic [2:0] c);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    // Behavioural model: what the MEM slot and flags must hold after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_n, m_v, m_z} = 3'b000;
            {m_valid, m_rw, m_mr, m_mw} = 4'b0000;
            m_res = 0; m_sd = 0; m_rd = 0;
        end else begin
            if (ex_valid && !stall && !flush && !ex_is_branch) begin
                if (ex_flag_we == 2'b10) {m_n, m_v, m_z} = {ex_n, ex_v, ex_z};
                else if (ex_flag_we == 2'b01) m_z = ex_z;
            end
            if (flush) begin
                {m_valid, m_rw, m_mr, m_mw} = 4'b0000;
            end else if (!stall) begin
                m_valid = ex_valid;
                m_res   = ex_result;
                m_sd    = ex_store_data;
                m_rd    = ex_rd;
                m_rw    = ex_valid && !ex_is_branch && ex_regwrite;
                m_mr    = ex_valid && !ex_is_branch && ex_memread;
                m_mw    = ex_valid && !ex_is_branch && ex_memwrite;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("br_taken", 32'(br_taken),
                32'(!rst && ex_valid && !stall && !flush && ex_is_branch && cond_ok(m_n, m_v, m_z, ex_cond)));
            chk("flags", 32'({flag_n, flag_v, flag_z}), 32'({m_n, m_v, m_z}));
            chk("mem_valid", 32'(mem_valid), 32'(m_valid));
            chk("mem_ctrl", 32'({mem_regwrite, mem_memread, mem_memwrite}), 32'({m_rw, m_mr, m_mw}));
            if (m_valid) begin
                chk("mem_result", 32'(mem_result), 32'(m_res));
                chk("mem_store_data", 32'(mem_store_data), 32'(m_sd));
                chk("mem_rd", 32'(mem_rd), 32'(m_rd));
            end
        end
    end

    task automatic idle();
        stall = 0; flush = 0; ex_valid = 0; ex_result = 0; ex_store_data = 0;
        ex_n = 0; ex_v = 0; ex_z = 0; ex_flag_we = 0; ex_is_branch = 0; ex_cond = 0;
        ex_rd = 0; ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [1:0] fwe, input logic n, input logic v, input logic z,
                       input logic [15:0] res);
        idle();
        ex_valid = 1; ex_flag_we = fwe; ex_n = n; ex_v = v; ex_z = z;
        ex_result = res; ex_rd = 4'd3; ex_regwrite = 1;
    endtask

    task automatic branch(input logic [2:0] cond, input logic [15:0] res);
        idle();
        ex_valid = 1; ex_is_branch = 1; ex_cond = cond; ex_result = res;
        ex_flag_we = 2'b10; ex_n = 1; ex_v = 1; ex_z = 1;
        ex_regwrite = 1; ex_memwrite = 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_flags"}, 32'({flag_n, flag_v, flag_z}), 32'd0);
        chk({tag, "_br"}, 32'(br_taken), 32'd0);
        chk({tag, "_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_ctrl"}, 32'({mem_regwrite, mem_memread, mem_memwrite}), 32'd0);
        chk({tag, "_data"}, 32'({mem_result, mem_store_data}), 32'd0);
        chk({tag, "_rd"}, 32'(mem_rd), 32'd0);
    endtask

    initial begin
        idle();
        rst = 1;
        ex_valid = 1; ex_is_branch = 1; ex_cond = 3'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("in_reset");
        idle();
        rst = 0;
        check_en = 1;
        tick();
        check_all_zero("after_release");

        // ADD sets N only
        alu(2'b10, 1, 0, 0, 16'h1234);
        tick();
        chk("add_flags", 32'({flag_n, flag_v, flag_z}), 32'b100);
        chk("add_result", 32'(mem_result), 32'h1234);
        chk("add_valid_rw", 32'({mem_valid, mem_regwrite, mem_rd}), 32'({1'b1, 1'b1, 4'd3}));

        // XOR updates Z only
        alu(2'b01, 0, 1, 1, 16'h0000);
        tick();
        chk("xor_flags", 32'({flag_n, flag_v, flag_z}), 32'b101);

        branch(3'd5, 16'hB005);
        #1 chk("lte_taken", 32'(br_taken), 32'd1);
        tick();
        chk("br_no_flag_write", 32'({flag_n, flag_v, flag_z}), 32'b101);
        chk("br_mem_ctrl", 32'({mem_valid, mem_regwrite, mem_memread, mem_memwrite}), 32'b1000);

        branch(3'd2, 16'hB002);
        #1 chk("gt_not_taken", 32'(br_taken), 32'd0);
        tick();

        // SUB with V=1 immediately followed by OVFL branch
        alu(2'b10, 0, 1, 0, 16'h5555);
        tick();
        branch(3'd6, 16'hB006);
        #1 chk("ovfl_b2b", 32'(br_taken), 32'd1);
        tick();

        // unconditional branch held by stall for 3 cycles
        branch(3'd7, 16'h7777);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall_br", 32'(br_taken), 32'd0);
            tick();
            chk("stall_hold", 32'({mem_valid, mem_result}), 32'({1'b1, 16'hB006}));
        end
        stall = 0;
        #1 chk("release_br", 32'(br_taken), 32'd1);
        tick();
        chk("release_mem", 32'({mem_valid, mem_result, mem_regwrite}), 32'({1'b1, 16'h7777, 1'b0}));
        idle();
        #1 chk("after_release_br", 32'(br_taken), 32'd0);

        // flushed load, then flush+stall
        for (int k = 0; k < 2; k++) begin
            idle();
            ex_valid = 1; ex_regwrite = 1; ex_memread = 1; ex_rd = 4'd5;
            ex_flag_we = 2'b10; ex_n = 1; ex_v = 0; ex_z = 1;
            flush = 1; stall = (k == 1);
            tick();
            chk("flush_valid_ctrl", 32'({mem_valid, mem_regwrite, mem_memread}), 32'd0);
            chk("flush_flags", 32'({flag_n, flag_v, flag_z}), 32'b010);
        end

        // randomized traffic, checked by the compare process
        for (int c = 0; c < 600; c++) begin
            stall         = ($urandom_range(0, 5) == 0);
            flush         = ($urandom_range(0, 7) == 0);
            ex_valid      = ($urandom_range(0, 3) != 0);
            ex_result     = 16'($urandom);
            ex_store_data = 16'($urandom);
            ex_n          = 1'($urandom);
            ex_v          = 1'($urandom);
            ex_z          = 1'($urandom);
            ex_flag_we    = 2'($urandom);
            ex_is_branch  = ($urandom_range(0, 3) == 0);
            ex_cond       = 3'($urandom);
            ex_rd         = 4'($urandom);
            ex_regwrite   = 1'($urandom);
            ex_memread    = 1'($urandom);
            ex_memwrite   = 1'($urandom);
            tick();
        end

        // asynchronous reset mid-cycle
        alu(2'b10, 1, 1, 1, 16'hABCD);
        tick();
        chk("pre_rst_state", 32'({flag_n, flag_v, flag_z, mem_valid}), 32'b1111);
        #2 rst = 1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 0;
        idle();
        ex_valid = 1; ex_rd = 4'd9; ex_regwrite = 1; ex_result = 16'h0F0F;
        tick();
        chk("first_capture", 32'({mem_valid, mem_rd, mem_regwrite, mem_result}),
            32'({1'b1, 4'd9, 1'b1, 16'h0F0F}));
        idle();
        tick();
        @(negedge clk);
        check_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
